// File: rtl/cp0_regfile_pkg.sv
// Shared CP0 definitions: register addresses, WB->CP0 bus layout, exception codes
// and the Status/Cause bit positions used by the register file.
package cp0_regfile_pkg;

    localparam logic [4:0] CP0_BADVADDR = 5'd8;
    localparam logic [4:0] CP0_COUNT    = 5'd9;
    localparam logic [4:0] CP0_COMPARE  = 5'd11;
    localparam logic [4:0] CP0_STATUS   = 5'd12;
    localparam logic [4:0] CP0_CAUSE    = 5'd13;
    localparam logic [4:0] CP0_EPC      = 5'd14;

    localparam logic [4:0] EXCODE_INT  = 5'h00;
    localparam logic [4:0] EXCODE_ADEL = 5'h04;
    localparam logic [4:0] EXCODE_ADES = 5'h05;
    localparam logic [4:0] EXCODE_SYS  = 5'h08;
    localparam logic [4:0] EXCODE_BP   = 5'h09;
    localparam logic [4:0] EXCODE_RI   = 5'h0a;
    localparam logic [4:0] EXCODE_OV   = 5'h0c;

    localparam int STATUS_BEV       = 22;
    localparam int STATUS_IM_LO     = 8;
    localparam int STATUS_EXL       = 1;
    localparam int STATUS_IE        = 0;
    localparam int CAUSE_BD         = 31;
    localparam int CAUSE_TI         = 30;
    localparam int CAUSE_IP_LO      = 8;
    localparam int CAUSE_EXCCODE_LO = 2;

    // Field order mirrors the 110-bit bus, MSB first.
    typedef struct packed {
        logic        ex;
        logic [4:0]  excode;
        logic [31:0] badvaddr;
        logic        bd;
        logic [31:0] pc;
        logic        mtc0_we;
        logic [4:0]  addr;
        logic [31:0] wdata;
        logic        eret;
    } cp0_bus_t;

    function automatic logic is_addr_excode(input logic [4:0] code);
        return (code == EXCODE_ADEL) || (code == EXCODE_ADES);
    endfunction

endpackage

// File: rtl/cp0_timer.sv
// CP0 timer: clock divider, Count, Compare and the sticky timer-interrupt flag.
module cp0_timer
    import cp0_regfile_pkg::*;
#(
    parameter int COUNT_DIV = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        count_we,
    input  logic        compare_we,
    input  logic [31:0] wdata,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        ti
);

    localparam logic [3:0] DIV_LAST = 4'(COUNT_DIV - 1);

    logic [3:0]  div_r;
    logic [31:0] count_r;
    logic [31:0] compare_r;
    logic        ti_r;

    // Divider and Count; a software load restarts the divide period.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            div_r   <= 4'd0;
            count_r <= 32'd0;
        end else if (count_we) begin
            div_r   <= 4'd0;
            count_r <= wdata;
        end else if (div_r == DIV_LAST) begin
            div_r   <= 4'd0;
            count_r <= count_r + 32'd1;
        end else begin
            div_r   <= div_r + 4'd1;
        end
    end

    // Compare register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            compare_r <= 32'd0;
        end else if (compare_we) begin
            compare_r <= wdata;
        end
    end

    // TI: match uses pre-increment Count; a Compare write beats a match.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ti_r <= 1'b0;
        end else if (compare_we) begin
            ti_r <= 1'b0;
        end else if (count_r == compare_r) begin
            ti_r <= 1'b1;
        end
    end

    assign count   = count_r;
    assign compare = compare_r;
    assign ti      = ti_r;

endmodule

// File: rtl/cp0_regfile.sv
// Coprocessor-0 register file: applies WB commits (exception, eret, mtc0),
// serves mfc0 reads, raises has_int and exposes EPC for eret redirect.
module cp0_regfile
    import cp0_regfile_pkg::*;
#(
    parameter int CP0_BUS_WD = 110,
    parameter int COUNT_DIV  = 2
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [CP0_BUS_WD-1:0] wb_to_cp0_register_bus,
    input  logic [5:0]            ext_int_in,
    output logic [31:0]           cp0_rdata,
    output logic                  has_int,
    output logic [31:0]           cp0_epc
);

    cp0_bus_t    bus_s;
    logic        eret_s;
    logic        mtc0_s;
    logic        wr_status_s;
    logic        wr_cause_s;
    logic        wr_epc_s;
    logic        wr_count_s;
    logic        wr_compare_s;
    logic [31:0] exc_epc_s;
    logic [31:0] status_s;
    logic [31:0] cause_s;
    logic [31:0] count_s;
    logic [31:0] compare_s;
    logic        ti_s;

    logic [7:0]  im_r;
    logic        exl_r;
    logic        ie_r;
    logic        bd_r;
    logic [5:0]  ip_hw_r;
    logic [1:0]  ip_sw_r;
    logic [4:0]  exccode_r;
    logic [31:0] epc_r;
    logic [31:0] badvaddr_r;

    assign bus_s = wb_to_cp0_register_bus;

    // An exception masks eret and mtc0; eret masks mtc0.
    assign eret_s       = ~bus_s.ex & bus_s.eret;
    assign mtc0_s       = ~bus_s.ex & ~bus_s.eret & bus_s.mtc0_we;
    assign wr_status_s  = mtc0_s & (bus_s.addr == CP0_STATUS);
    assign wr_cause_s   = mtc0_s & (bus_s.addr == CP0_CAUSE);
    assign wr_epc_s     = mtc0_s & (bus_s.addr == CP0_EPC);
    assign wr_count_s   = mtc0_s & (bus_s.addr == CP0_COUNT);
    assign wr_compare_s = mtc0_s & (bus_s.addr == CP0_COMPARE);
    assign exc_epc_s    = bus_s.bd ? (bus_s.pc - 32'd4) : bus_s.pc;

    cp0_timer #(
        .COUNT_DIV (COUNT_DIV)
    ) u_timer (
        .clk        (clk),
        .resetn     (resetn),
        .count_we   (wr_count_s),
        .compare_we (wr_compare_s),
        .wdata      (bus_s.wdata),
        .count      (count_s),
        .compare    (compare_s),
        .ti         (ti_s)
    );

    // Status: EXL set on exception, cleared by eret, otherwise software-writable.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            im_r  <= 8'd0;
            exl_r <= 1'b0;
            ie_r  <= 1'b0;
        end else if (bus_s.ex) begin
            exl_r <= 1'b1;
        end else if (eret_s) begin
            exl_r <= 1'b0;
        end else if (wr_status_s) begin
            im_r  <= bus_s.wdata[15:8];
            exl_r <= bus_s.wdata[1];
            ie_r  <= bus_s.wdata[0];
        end
    end

    // Exception capture; nested exceptions (EXL already set) keep EPC and BD.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            exccode_r  <= 5'd0;
            bd_r       <= 1'b0;
            epc_r      <= 32'd0;
            badvaddr_r <= 32'd0;
        end else if (bus_s.ex) begin
            exccode_r <= bus_s.excode;
            if (!exl_r) begin
                epc_r <= exc_epc_s;
                bd_r  <= bus_s.bd;
            end
            if (is_addr_excode(bus_s.excode)) begin
                badvaddr_r <= bus_s.badvaddr;
            end
        end else if (wr_epc_s) begin
            epc_r <= bus_s.wdata;
        end
    end

    // Pending-interrupt bits: hardware lines sampled every clock, software bits by mtc0.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ip_hw_r <= 6'd0;
            ip_sw_r <= 2'd0;
        end else begin
            ip_hw_r <= {ext_int_in[5] | ti_s, ext_int_in[4:0]};
            if (wr_cause_s) begin
                ip_sw_r <= bus_s.wdata[9:8];
            end
        end
    end

    // Architectural views of Status and Cause; unimplemented bits read zero.
    always_comb begin
        status_s                                = 32'd0;
        status_s[STATUS_BEV]                    = 1'b1;
        status_s[STATUS_IM_LO +: 8]             = im_r;
        status_s[STATUS_EXL]                    = exl_r;
        status_s[STATUS_IE]                     = ie_r;
        cause_s                                 = 32'd0;
        cause_s[CAUSE_BD]                       = bd_r;
        cause_s[CAUSE_TI]                       = ti_s;
        cause_s[CAUSE_IP_LO +: 8]               = {ip_hw_r, ip_sw_r};
        cause_s[CAUSE_EXCCODE_LO +: 5]          = exccode_r;
    end

    // mfc0 read mux.
    always_comb begin
        cp0_rdata = 32'd0;
        case (bus_s.addr)
            CP0_BADVADDR: cp0_rdata = badvaddr_r;
            CP0_COUNT:    cp0_rdata = count_s;
            CP0_COMPARE:  cp0_rdata = compare_s;
            CP0_STATUS:   cp0_rdata = status_s;
            CP0_CAUSE:    cp0_rdata = cause_s;
            CP0_EPC:      cp0_rdata = epc_r;
            default:      cp0_rdata = 32'd0;
        endcase
    end

    assign has_int = ie_r & ~exl_r & (|({ip_hw_r, ip_sw_r} & im_r));
    assign cp0_epc = epc_r;

endmodule

// File: tb/tb_cp0_regfile.sv
// Self-checking bench for cp0_regfile: directed literal checks plus randomized
// commits compared every cycle against a behavioural CP0 model.
module tb_cp0_regfile;

    localparam int COUNT_DIV = 2;
    localparam logic [4:0] A_BADV    = 5'd8;
    localparam logic [4:0] A_COUNT   = 5'd9;
    localparam logic [4:0] A_COMPARE = 5'd11;
    localparam logic [4:0] A_STATUS  = 5'd12;
    localparam logic [4:0] A_CAUSE   = 5'd13;
    localparam logic [4:0] A_EPC     = 5'd14;

    logic         clk = 1'b0;
    logic         resetn = 1'b0;
    logic [109:0] bus = '0;
    logic [5:0]   ext_int_in = 6'd0;
    logic [31:0]  cp0_rdata;
    logic         has_int;
    logic [31:0]  cp0_epc;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cp0_regfile #(
        .CP0_BUS_WD (110),
        .COUNT_DIV  (COUNT_DIV)
    ) dut (
        .clk                    (clk),
        .resetn                 (resetn),
        .wb_to_cp0_register_bus (bus),
        .ext_int_in             (ext_int_in),
        .cp0_rdata              (cp0_rdata),
        .has_int                (has_int),
        .cp0_epc                (cp0_epc)
    );

    // Behavioural model: Count is a load value plus elapsed clocks / COUNT_DIV.
    logic [7:0]  m_im;
    logic        m_exl, m_ie, m_bd, m_ti;
    logic [5:0]  m_ip_hw;
    logic [1:0]  m_ip_sw;
    logic [4:0]  m_exc;
    logic [31:0] m_epc, m_badv, m_compare, m_count_base;
    int unsigned m_ticks;

    function automatic logic [31:0] m_count();
        return m_count_base + 32'(m_ticks / COUNT_DIV);
    endfunction

    function automatic logic m_has_int();
        return m_ie && !m_exl && (({m_ip_hw, m_ip_sw} & m_im) != 8'd0);
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        case (a)
            A_BADV:    return m_badv;
            A_COUNT:   return m_count();
            A_COMPARE: return m_compare;
            A_STATUS:  return 32'h0040_0000 | (32'(m_im) << 8) | (32'(m_exl) << 1) | 32'(m_ie);
            A_CAUSE:   return (32'(m_bd) << 31) | (32'(m_ti) << 30) | (32'(m_ip_hw) << 10)
                              | (32'(m_ip_sw) << 8) | (32'(m_exc) << 2);
            A_EPC:     return m_epc;
            default:   return 32'd0;
        endcase
    endfunction

    always @(posedge clk or negedge resetn) begin
        logic        f_ex, f_bd, f_we, f_eret, f_mtc0;
        logic [4:0]  f_exc, f_addr;
        logic [31:0] f_badv, f_pc, f_wd, cnt;
        if (!resetn) begin
            m_im = 8'd0; m_exl = 1'b0; m_ie = 1'b0; m_bd = 1'b0; m_ti = 1'b0;
            m_ip_hw = 6'd0; m_ip_sw = 2'd0; m_exc = 5'd0;
            m_epc = 32'd0; m_badv = 32'd0; m_compare = 32'd0; m_count_base = 32'd0;
            m_ticks = 0;
        end else begin
            {f_ex, f_exc, f_badv, f_bd, f_pc, f_we, f_addr, f_wd, f_eret} = bus;
            f_mtc0 = !f_ex && !f_eret && f_we;
            cnt = m_count();
            m_ip_hw = {ext_int_in[5] | m_ti, ext_int_in[4:0]};
            if (f_mtc0 && f_addr == A_COMPARE) begin
                m_compare = f_wd;
                m_ti = 1'b0;
            end else if (cnt == m_compare) begin
                m_ti = 1'b1;
            end
            if (f_mtc0 && f_addr == A_COUNT) begin
                m_count_base = f_wd;
                m_ticks = 0;
            end else begin
                m_ticks = m_ticks + 1;
            end
            if (f_ex) begin
                m_exc = f_exc;
                if (!m_exl) begin
                    m_epc = f_bd ? f_pc - 32'd4 : f_pc;
                    m_bd = f_bd;
                end
                m_exl = 1'b1;
                if (f_exc == 5'h04 || f_exc == 5'h05) m_badv = f_badv;
            end else if (f_eret) begin
                m_exl = 1'b0;
            end else if (f_we) begin
                case (f_addr)
                    A_STATUS: begin m_im = f_wd[15:8]; m_exl = f_wd[1]; m_ie = f_wd[0]; end
                    A_CAUSE:  m_ip_sw = f_wd[9:8];
                    A_EPC:    m_epc = f_wd;
                    default:  ;
                endcase
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        check("model_rdata", cp0_rdata, m_read(bus[37:33]));
        check("model_has_int", {31'd0, has_int}, {31'd0, m_has_int()});
        check("model_epc", cp0_epc, m_epc);
    end

    function automatic logic [109:0] mk_bus(input logic ex, input logic [4:0] excode,
        input logic [31:0] badv, input logic bd, input logic [31:0] pc, input logic we,
        input logic [4:0] addr, input logic [31:0] wd, input logic eret);
        return {ex, excode, badv, bd, pc, we, addr, wd, eret};
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic commit(input logic [109:0] v);
        bus = v;
        cyc(1);
        bus = '0;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        commit(mk_bus(1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b1, a, d, 1'b0));
    endtask

    task automatic lit(input string name, input logic [4:0] a, input logic [31:0] exp);
        bus = mk_bus(1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b0, a, 32'd0, 1'b0);
        #1;
        check(name, cp0_rdata, exp);
    endtask

    initial begin
        logic [4:0]  addr_tab [7];
        logic [4:0]  ra;
        logic [31:0] rd;
        int          r;
        bit          seen;
        addr_tab = '{A_BADV, A_COUNT, A_COMPARE, A_STATUS, A_CAUSE, A_EPC, 5'd0};

        // Reset values and first Count increments.
        repeat (3) @(posedge clk);
        #1;
        resetn = 1'b1;
        lit("reset_status", A_STATUS, 32'h0040_0000);
        check("reset_has_int", {31'd0, has_int}, 32'd0);
        lit("reset_count0", A_COUNT, 32'd0);
        cyc(2);
        lit("count_after_2", A_COUNT, 32'd1);
        cyc(2);
        lit("count_after_4", A_COUNT, 32'd2);

        // Interrupt enable path via software IP.
        mtc0(A_COMPARE, 32'hFFFF_0000);
        mtc0(A_STATUS, 32'h0000_FF01);
        check("has_int_no_ip", {31'd0, has_int}, 32'd0);
        mtc0(A_CAUSE, 32'h0000_0100);
        check("has_int_sw_ip", {31'd0, has_int}, 32'd1);
        lit("cause_sw_ip", A_CAUSE, 32'h0000_0100);
        mtc0(A_STATUS, 32'h0000_FF03);
        check("has_int_exl", {31'd0, has_int}, 32'd0);
        lit("status_exl", A_STATUS, 32'h0040_FF03);
        mtc0(A_STATUS, 32'd0);
        mtc0(A_CAUSE, 32'd0);

        // Exceptions: delay slot, BadVAddr capture, nested exception.
        commit(mk_bus(1'b1, 5'h04, 32'h1234_5671, 1'b1, 32'hBFC0_0100, 1'b0, 5'd0, 32'd0, 1'b0));
        check("ex_epc", cp0_epc, 32'hBFC0_00FC);
        lit("ex_cause", A_CAUSE, 32'h8000_0010);
        lit("ex_badv", A_BADV, 32'h1234_5671);
        lit("ex_status", A_STATUS, 32'h0040_0002);
        commit(mk_bus(1'b1, 5'h0c, 32'hDEAD_BEEF, 1'b0, 32'h8000_0000, 1'b0, 5'd0, 32'd0, 1'b0));
        check("nested_epc", cp0_epc, 32'hBFC0_00FC);
        lit("nested_cause", A_CAUSE, 32'h8000_0030);
        lit("nested_badv", A_BADV, 32'h1234_5671);

        // eret, then ex+eret+mtc0 in one commit.
        commit(mk_bus(1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1));
        lit("eret_status", A_STATUS, 32'h0040_0000);
        check("eret_epc", cp0_epc, 32'hBFC0_00FC);
        commit(mk_bus(1'b1, 5'h08, 32'd0, 1'b0, 32'h8000_1000, 1'b1, A_STATUS, 32'h0000_FFFF, 1'b1));
        lit("ex_eret_status", A_STATUS, 32'h0040_0002);
        check("ex_eret_epc", cp0_epc, 32'h8000_1000);
        lit("ex_eret_cause", A_CAUSE, 32'h0000_0020);
        commit(mk_bus(1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1));

        // Timer interrupt.
        mtc0(A_COMPARE, 32'd5);
        mtc0(A_COUNT, 32'd0);
        mtc0(A_STATUS, 32'h0000_8001);
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            if (has_int) seen = 1'b1;
            else cyc(1);
        end
        check("timer_has_int", {31'd0, seen}, 32'd1);
        lit("timer_count", A_COUNT, 32'd6);
        lit("timer_cause", A_CAUSE, 32'h4000_8020);
        mtc0(A_COMPARE, 32'h0000_0100);
        lit("ti_cleared", A_CAUSE, 32'h0000_8020);
        cyc(1);
        check("ti_has_int_off", {31'd0, has_int}, 32'd0);

        // External interrupt line 2.
        mtc0(A_STATUS, 32'h0000_1001);
        ext_int_in = 6'b000100;
        cyc(1);
        lit("ext_ip12", A_CAUSE, 32'h0000_1020);
        check("ext_has_int", {31'd0, has_int}, 32'd1);
        ext_int_in = 6'd0;
        cyc(1);
        lit("ext_ip12_off", A_CAUSE, 32'h0000_0020);
        check("ext_has_int_off", {31'd0, has_int}, 32'd0);

        // Randomized commits against the model, with one mid-run reset.
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) begin
                bus = '0;
                resetn = 1'b0;
                cyc(3);
                resetn = 1'b1;
                lit("rst_count0", A_COUNT, 32'd0);
                cyc(2);
                lit("rst_count1", A_COUNT, 32'd1);
            end
            r  = int'($urandom_range(0, 99));
            ra = addr_tab[$urandom_range(0, 6)];
            if (ra == 5'd0) ra = 5'($urandom);
            rd = $urandom;
            if (r < 35)
                bus = mk_bus(1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b0, ra, rd, 1'b0);
            else if (r < 65)
                bus = mk_bus(1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b1, ra, rd, 1'b0);
            else if (r < 75)
                bus = mk_bus(1'b1, ($urandom_range(0, 1) == 0) ? 5'h04 : 5'($urandom), $urandom,
                             1'($urandom), $urandom, 1'($urandom), ra, rd, 1'b0);
            else if (r < 83)
                bus = mk_bus(1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 1'($urandom), ra, rd, 1'b1);
            else if (r < 88)
                bus = mk_bus(1'b1, 5'h05, $urandom, 1'b0, $urandom, 1'b1, ra, rd, 1'b1);
            else if (r < 95)
                bus = mk_bus(1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b1, A_COUNT,
                             m_compare - 32'($urandom_range(0, 6)), 1'b0);
            else
                bus = mk_bus(1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b1, A_COUNT,
                             32'hFFFF_FFFE, 1'b0);
            if ($urandom_range(0, 3) == 0) ext_int_in = 6'($urandom);
            cyc(1);
        end
        bus = '0;
        cyc(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
